// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4-Lite slave over a word SRAM, one transaction in flight, fixed read latency
// clk, rst (async active-low); AW/W/B write channels; AR/R read channels; resp 2'b10 = out of range
module axi_sram_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                io_awvalid,
    output logic                io_awready,
    input  logic [ADDR_W-1:0]   io_awaddr,
    input  logic                io_wvalid,
    output logic                io_wready,
    input  logic [DATA_W-1:0]   io_wdata,
    input  logic [DATA_W/8-1:0] io_wstrb,
    output logic                io_bvalid,
    input  logic                io_bready,
    output logic [1:0]          io_bresp,
    input  logic                io_arvalid,
    output logic                io_arready,
    input  logic [ADDR_W-1:0]   io_araddr,
    output logic                io_rvalid,
    input  logic                io_rready,
    output logic [DATA_W-1:0]   io_rdata,
    output logic [1:0]          io_rresp
);
    localparam int IW = $clog2(DEPTH);
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_RESP} state_t;
    state_t              state;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   raddr, waddr_q, waddr, rd_addr;
    logic [DATA_W-1:0]   wdata_q, wdata;
    logic [DATA_W/8-1:0] wstrb_q, wstrb;
    logic                aw_got, w_got, ar_take, aw_take, w_take, have_aw, have_w, wr_go, rd_go;
    logic [DATA_W-1:0]   mem [DEPTH];

    function automatic logic oor(input logic [ADDR_W-1:0] a);
        return (a >> (IW + 2)) != '0;
    endfunction

    // the write commits on the edge where the second channel lands, using live inputs for it
    always_comb begin
        ar_take = io_arvalid && io_arready;
        aw_take = io_awvalid && io_awready && !ar_take;
        w_take  = io_wvalid && io_wready && !ar_take;
        have_aw = aw_got || aw_take;
        have_w  = w_got || w_take;
        wr_go   = (state == IDLE || state == WR_COLLECT) && have_aw && have_w && !ar_take;
        waddr   = aw_got ? waddr_q : io_awaddr;
        wdata   = w_got ? wdata_q : io_wdata;
        wstrb   = w_got ? wstrb_q : io_wstrb;
        rd_addr = state == IDLE ? io_araddr : raddr;
        rd_go   = (ar_take && RD_LAT == 1) || (state == RD_WAIT && cnt == 4'd1);
    end

    always_ff @(posedge clk)
        if (wr_go && !oor(waddr))
            for (int i = 0; i < DATA_W/8; i++)
                if (wstrb[i]) mem[waddr[IW+1:2]][8*i +: 8] <= wdata[8*i +: 8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            raddr      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            io_arready <= 1'b0;
            io_awready <= 1'b0;
            io_wready  <= 1'b0;
            io_rvalid  <= 1'b0;
            io_bvalid  <= 1'b0;
            io_rdata   <= '0;
            io_rresp   <= '0;
            io_bresp   <= '0;
        end else begin
            if (rd_go) begin
                io_rdata <= oor(rd_addr) ? '0 : mem[rd_addr[IW+1:2]];
                io_rresp <= oor(rd_addr) ? 2'b10 : 2'b00;
            end
            if (aw_take) waddr_q <= io_awaddr;
            if (w_take) begin
                wdata_q <= io_wdata;
                wstrb_q <= io_wstrb;
            end
            case (state)
                IDLE, WR_COLLECT:
                    if (ar_take) begin
                        raddr      <= io_araddr;
                        cnt        <= 4'(RD_LAT - 1);
                        state      <= RD_LAT == 1 ? RD_RESP : RD_WAIT;
                        io_rvalid  <= RD_LAT == 1;
                        io_arready <= 1'b0;
                        io_awready <= 1'b0;
                        io_wready  <= 1'b0;
                    end else if (wr_go) begin
                        aw_got     <= 1'b0;
                        w_got      <= 1'b0;
                        io_bresp   <= oor(waddr) ? 2'b10 : 2'b00;
                        io_bvalid  <= 1'b1;
                        state      <= WR_RESP;
                        io_arready <= 1'b0;
                        io_awready <= 1'b0;
                        io_wready  <= 1'b0;
                    end else begin
                        aw_got     <= have_aw;
                        w_got      <= have_w;
                        state      <= (have_aw || have_w) ? WR_COLLECT : IDLE;
                        io_arready <= !(have_aw || have_w);
                        io_awready <= !have_aw;
                        io_wready  <= !have_w;
                    end
                RD_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RD_RESP;
                        io_rvalid <= 1'b1;
                    end
                end
                RD_RESP:
                    if (io_rready) begin
                        io_rvalid  <= 1'b0;
                        state      <= IDLE;
                        io_arready <= 1'b1;
                        io_awready <= 1'b1;
                        io_wready  <= 1'b1;
                    end
                WR_RESP:
                    if (io_bready) begin
                        io_bvalid  <= 1'b0;
                        state      <= IDLE;
                        io_arready <= 1'b1;
                        io_awready <= 1'b1;
                        io_wready  <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed table, corner sequences and random traffic against a word-array model
module tb_axi_sram_slave;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1024;

    logic        clk = 1'b0, rst = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    axi_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .io_awvalid(awvalid), .io_awready(awready), .io_awaddr(awaddr),
        .io_wvalid(wvalid), .io_wready(wready), .io_wdata(wdata), .io_wstrb(wstrb),
        .io_bvalid(bvalid), .io_bready(bready), .io_bresp(bresp),
        .io_arvalid(arvalid), .io_arready(arready), .io_araddr(araddr),
        .io_rvalid(rvalid), .io_rready(rready), .io_rdata(rdata), .io_rresp(rresp)
    );

    int          vectors = 0, miscompares = 0;
    logic [31:0] ref_mem [DEPTH];

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  da;
        logic [3:0]  dw;
        logic [3:0]  dly;
        logic [31:0] exp;
        logic [1:0]  resp;
    } vec_t;
    vec_t tbl [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got no handshake, want one within 64 cycles", name);
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return a < 32'(DEPTH * 4) ? ref_mem[a[11:2]] : 32'h0;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return a < 32'(DEPTH * 4) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] rand_addr();
        int w;
        w = $urandom_range(0, 15);
        if ($urandom_range(0, 7) == 0)
            return 32'h1000 + 32'($urandom_range(0, 4095)) * 4 + 32'($urandom_range(0, 3));
        return 32'((w < 8 ? w : 1008 + w) * 4) + 32'($urandom_range(0, 3));
    endfunction

    task automatic send_aw(input logic [31:0] a);
        int n;
        n = 0;
        awvalid = 1'b1;
        awaddr  = a;
        while (!awready && n < 64) begin step(); n++; end
        if (!awready) timeout("awready");
        step();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
        while (!wready && n < 64) begin step(); n++; end
        if (!wready) timeout("wready");
        step();
        wvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int da, input int dw, input int bd, input logic [1:0] exp_resp);
        int n;
        n = 0;
        fork
            begin repeat (da) step(); send_aw(a); end
            begin repeat (dw) step(); send_w(d, s); end
        join
        while (!bvalid && n < 64) begin step(); n++; end
        if (!bvalid) timeout("bvalid");
        repeat (bd) begin chk("bvalid_hold", 32'(bvalid), 1); step(); end
        chk("bresp", 32'(bresp), 32'(exp_resp));
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("bvalid_clear", 32'(bvalid), 0);
        if (a < 32'(DEPTH * 4))
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[a[11:2]][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic do_read(input logic [31:0] a, input int rd, input logic [31:0] exp_d, input logic [1:0] exp_r);
        int n, lat;
        n = 0;
        lat = 1;
        arvalid = 1'b1;
        araddr  = a;
        while (!arready && n < 64) begin step(); n++; end
        if (!arready) timeout("arready");
        step();
        arvalid = 1'b0;
        while (!rvalid && lat < 64) begin step(); lat++; end
        chk("rd_latency", 32'(lat), 32'(RD_LAT));
        repeat (rd) begin
            chk("rvalid_hold", 32'(rvalid), 1);
            chk("rdata_hold", rdata, exp_d);
            step();
        end
        chk("rdata", rdata, exp_d);
        chk("rresp", 32'(rresp), 32'(exp_r));
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("rvalid_clear", 32'(rvalid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, want finish before 500us");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] a, d;
        logic [3:0]  s;
        // wr, addr, data, strb, da, dw, dly, exp, resp
        tbl.push_back(vec_t'{1'b1, 32'h100,      32'hDEADBEEF, 4'hF, 4'd0, 4'd0, 4'd0, 32'h0,        2'b00});
        tbl.push_back(vec_t'{1'b0, 32'h100,      32'h0,        4'h0, 4'd0, 4'd0, 4'd0, 32'hDEADBEEF, 2'b00});
        tbl.push_back(vec_t'{1'b1, 32'h4,        32'hFFFFFFFF, 4'hF, 4'd0, 4'd0, 4'd1, 32'h0,        2'b00});
        tbl.push_back(vec_t'{1'b1, 32'h4,        32'h11223344, 4'h5, 4'd3, 4'd0, 4'd0, 32'h0,        2'b00});
        tbl.push_back(vec_t'{1'b0, 32'h4,        32'h0,        4'h0, 4'd0, 4'd0, 4'd0, 32'hFF22FF44, 2'b00});
        tbl.push_back(vec_t'{1'b1, 32'h0,        32'hA5A5A5A5, 4'hF, 4'd0, 4'd2, 4'd0, 32'h0,        2'b00});
        tbl.push_back(vec_t'{1'b0, 32'h3,        32'h0,        4'h0, 4'd0, 4'd0, 4'd5, 32'hA5A5A5A5, 2'b00});
        tbl.push_back(vec_t'{1'b1, 32'h0,        32'h00000000, 4'h0, 4'd0, 4'd0, 4'd0, 32'h0,        2'b00});
        tbl.push_back(vec_t'{1'b0, 32'h0,        32'h0,        4'h0, 4'd0, 4'd0, 4'd0, 32'hA5A5A5A5, 2'b00});
        tbl.push_back(vec_t'{1'b1, 32'hFFC,      32'hCAFEF00D, 4'hF, 4'd1, 4'd1, 4'd0, 32'h0,        2'b00});
        tbl.push_back(vec_t'{1'b0, 32'hFFF,      32'h0,        4'h0, 4'd0, 4'd0, 4'd0, 32'hCAFEF00D, 2'b00});
        tbl.push_back(vec_t'{1'b1, 32'h1000,     32'h12345678, 4'hF, 4'd0, 4'd0, 4'd0, 32'h0,        2'b10});
        tbl.push_back(vec_t'{1'b0, 32'h1000,     32'h0,        4'h0, 4'd0, 4'd0, 4'd0, 32'h0,        2'b10});
        tbl.push_back(vec_t'{1'b0, 32'h0,        32'h0,        4'h0, 4'd0, 4'd0, 4'd0, 32'hA5A5A5A5, 2'b00});
        tbl.push_back(vec_t'{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 4'd0, 4'd0, 4'd0, 32'h0,        2'b10});
        tbl.push_back(vec_t'{1'b1, 32'h2000,     32'h0,        4'hF, 4'd0, 4'd0, 4'd0, 32'h0,        2'b10});
        tbl.push_back(vec_t'{1'b0, 32'h102,      32'h0,        4'h0, 4'd0, 4'd0, 4'd0, 32'hDEADBEEF, 2'b00});

        #1 rst = 1'b0;
        #2;
        chk("rst_arready", 32'(arready), 0);
        chk("rst_awready", 32'(awready), 0);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rdata", rdata, 0);
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("post_rst_arready", 32'(arready), 1);
        chk("post_rst_awready", 32'(awready), 1);
        chk("post_rst_wready", 32'(wready), 1);

        foreach (tbl[i])
            if (tbl[i].wr)
                do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, int'(tbl[i].da), int'(tbl[i].dw), int'(tbl[i].dly), tbl[i].resp);
            else
                do_read(tbl[i].addr, int'(tbl[i].dly), tbl[i].exp, tbl[i].resp);

        // reset while the read is still counting down: no response, memory kept
        araddr  = 32'h100;
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("abort_rvalid", 32'(rvalid), 0);
        chk("abort_arready", 32'(arready), 0);
        chk("abort_awready", 32'(awready), 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_bresp", 32'(bresp), 0);
        repeat (3) step();
        rst = 1'b1;
        repeat (5) begin step(); chk("abort_no_rvalid", 32'(rvalid), 0); end
        do_read(32'h100, 0, 32'hDEADBEEF, 2'b00);

        // read and write raised together: read wins, write waits for the R handshake
        araddr  = 32'h100;
        arvalid = 1'b1;
        awaddr  = 32'h8;
        awvalid = 1'b1;
        wdata   = 32'h5555AAAA;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        chk("prio_arready", 32'(arready), 1);
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 64) begin
            chk("prio_awready_low", 32'(awready), 0);
            chk("prio_wready_low", 32'(wready), 0);
            step();
            n++;
        end
        chk("prio_rdata", rdata, 32'hDEADBEEF);
        chk("prio_awready_in_rresp", 32'(awready), 0);
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("prio_awready_after_r", 32'(awready), 1);
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("prio_bvalid", 32'(bvalid), 1);
        chk("prio_bresp", 32'(bresp), 0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        ref_mem[2] = 32'h5555AAAA;
        do_read(32'h8, 0, 32'h5555AAAA, 2'b00);

        for (int i = 0; i < 16; i++)
            do_write(32'((i < 8 ? i : 1008 + i) * 4), $urandom, 4'hF, 0, 0, 0, 2'b00);
        for (int k = 0; k < 300; k++) begin
            a = rand_addr();
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), model_resp(a));
            end else
                do_read(a, $urandom_range(0, 3), model_rd(a), model_resp(a));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; the only supported value is 32.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words, power of two.
REQ-004 SHALL have parameter RD_LAT, default 2, meaning cycles from AR handshake to first RVALID; legal range 1..15.
REQ-005 SHALL have port clk  in  1  meaning the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  meaning reset, asynchronous, active-low.
REQ-007 SHALL have ports io_awvalid in 1, io_awready out 1, io_awaddr in ADDR_W, meaning the write-address channel.
REQ-008 SHALL have ports io_wvalid in 1, io_wready out 1, io_wdata in 32, io_wstrb in 4, meaning the write-data channel.
REQ-009 SHALL have ports io_bvalid out 1, io_bready in 1, io_bresp out 2, meaning the write-response channel.
REQ-010 SHALL have ports io_arvalid in 1, io_arready out 1, io_araddr in ADDR_W, meaning the read-address channel.
REQ-011 SHALL have ports io_rvalid out 1, io_rready in 1, io_rdata out 32, io_rresp out 2, meaning the read-data channel.

Function
REQ-012 SHALL implement an AXI4-Lite slave: single-beat transactions, one transaction in flight in total, no IDs.
REQ-013 SHALL use FSM states IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_RESP.
REQ-014 SHALL assert io_arready only in IDLE; io_awready and io_wready only in IDLE/WR_COLLECT while that channel is not yet captured.
REQ-015 SHALL, in IDLE with io_arvalid and io_awvalid both high, accept the read and hold AW/W off (read priority).
REQ-016 SHALL, in IDLE, on the AR handshake, latch io_araddr, load the latency counter with RD_LAT-1, and go to RD_WAIT; RD_LAT=1 goes directly to RD_RESP.
REQ-017 SHALL decrement the counter in RD_WAIT, enter RD_RESP when it reaches 0, and read the memory word at araddr[log2(DEPTH)+1:2].
REQ-018 SHALL hold io_rvalid, io_rdata and io_rresp stable in RD_RESP until io_rready is high, then return to IDLE on that edge.
REQ-019 SHALL, on a write, capture AW and W independently in any order or in the same cycle, going IDLE->WR_COLLECT on the first capture when only one is present.
REQ-020 SHALL, once both AW and W are captured, write the memory byte lanes selected by wstrb in one cycle and enter WR_RESP; wstrb=0 writes nothing and returns OKAY.
REQ-021 SHALL hold io_bvalid and io_bresp in WR_RESP until io_bready is high, then return to IDLE.
REQ-022 SHALL treat address bits [1:0] as ignored, with word-aligned access only.
REQ-023 SHALL treat an address >= DEPTH*4 as out of range: a read returns rdata=0 and rresp=2'b10 (SLVERR); a write modifies no memory and returns bresp=2'b10.
REQ-024 SHALL otherwise return resp=2'b00 (OKAY).
REQ-025 SHALL make a read issued after a write's B handshake observe the written data, with no hazard window.
REQ-026 SHALL drive all ready/valid outputs directly from registered state, with no combinational input-to-output path.

Reset
REQ-027 SHALL, on rst low, immediately force state=IDLE; io_awready, io_wready, io_bvalid, io_rvalid=0; io_arready=0; rdata=0; resp outputs=0; capture flags and counter cleared.
REQ-028 SHALL assert io_arready, io_awready and io_wready in the first cycle after rst deasserts.
REQ-029 SHALL leave memory contents unaffected by reset, and SHALL abort any in-flight transaction, with no response issued.

Verification
REQ-030 SHALL cover: RD_LAT=2, write 0x100<=0xDEADBEEF, wstrb=0xF, then read 0x100 -> rvalid 2 cycles after AR handshake, rdata=0xDEADBEEF, rresp=0.
REQ-031 SHALL cover: W presented 3 cycles before AW, address 0x4, wdata=0x11223344, wstrb=0x5 over old 0xFFFFFFFF -> bresp=0, then reading 0x4 returns 0xFF22FF44.
REQ-032 SHALL cover: arvalid and awvalid both raised in the same cycle in IDLE -> read completes first, awready low until the R handshake, then the write completes.
REQ-033 SHALL cover: read 0x1000 with DEPTH=1024 -> rresp=2'b10, rdata=0; write 0x1000 -> bresp=2'b10, and word 0 is unchanged.
REQ-034 SHALL cover: rready held low 5 cycles in RD_RESP -> rvalid/rdata stable for all 5 cycles, and single-cycle completion once rready rises.
REQ-035 SHALL cover: rst pulsed low during RD_WAIT -> rvalid never asserts, outputs reset asynchronously, and a subsequent read returns correct data.
